// File: rtl/cordic_out_serializer.sv
// cordic_out_serializer
//   Buffers 56-bit CORDIC results in a small FIFO and streams each word
//   off-chip LSB-chunk-first as SER_WIDTH-bit beats under valid/ready,
//   with start/end-of-frame markers. Words arriving while the FIFO is
//   full (and no pop is happening) are dropped and counted.
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_vld, i_data          result word from the CORDIC wrapper (no backpressure)
//   o_ser_vld/data/sof/eof serial beat stream; i_ser_rdy accepts a beat
//   o_ovf, o_drop_cnt      sticky overflow flag, saturating drop count
//   i_ovf_clr              clears o_ovf/o_drop_cnt (a same-cycle drop wins)
//   o_fifo_level           words in the FIFO, excluding the one being shifted
//   o_busy                 FIFO non-empty or shifter active
module cordic_out_serializer #(
  parameter int DATA_WIDTH = 56,
  parameter int SER_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_vld,
  input  logic [DATA_WIDTH-1:0]          i_data,
  output logic                           o_ser_vld,
  output logic [SER_WIDTH-1:0]           o_ser_data,
  output logic                           o_ser_sof,
  output logic                           o_ser_eof,
  input  logic                           i_ser_rdy,
  output logic                           o_ovf,
  input  logic                           i_ovf_clr,
  output logic [CNT_WIDTH-1:0]           o_drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]    o_fifo_level,
  output logic                           o_busy
);

  localparam int NBEATS = DATA_WIDTH / SER_WIDTH;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [AW:0]           level;
  logic                  empty, full;
  logic                  push, pop, drop;
  logic                  is_last;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         beat;

  // Extra pointer MSB distinguishes full from empty.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign is_last = (beat == LAST_BEAT);

  // Pop either from IDLE or on the final handshake of a word, so that
  // consecutive words stream with no bubble.
  assign pop  = !empty && ((state_q == IDLE) ||
                           ((state_q == SHIFT) && i_ser_rdy && is_last));
  assign push = i_vld && (!full || pop);
  assign drop = i_vld && !push;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!empty) state_d = SHIFT;
      SHIFT: if (i_ser_rdy && is_last && empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_ser_vld  = (state_q == SHIFT);
    o_ser_data = shreg[SER_WIDTH-1:0];
    o_ser_sof  = o_ser_vld && (beat == '0);
    o_ser_eof  = o_ser_vld && is_last;
  end

  assign o_fifo_level = level;
  assign o_busy       = !empty || (state_q == SHIFT);

  // FIFO storage (no reset needed; validity is tracked by the pointers)
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Shift register and beat index
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg <= '0;
      beat  <= '0;
    end else if (pop) begin
      shreg <= mem[rd_ptr[AW-1:0]];
      beat  <= '0;
    end else if ((state_q == SHIFT) && i_ser_rdy && !is_last) begin
      shreg <= shreg >> SER_WIDTH;
      beat  <= beat + 1'b1;
    end
  end

  // Overflow reporting: a drop in the same cycle as a clear restarts at 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ovf      <= 1'b0;
      o_drop_cnt <= '0;
    end else if (drop) begin
      o_ovf <= 1'b1;
      if (i_ovf_clr)             o_drop_cnt <= CNT_WIDTH'(1);
      else if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 1'b1;
    end else if (i_ovf_clr) begin
      o_ovf      <= 1'b0;
      o_drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_cordic_out_serializer.sv
module tb_cordic_out_serializer;

  localparam int DW = 56;
  localparam int SW = 8;
  localparam int DEPTH = 4;
  localparam int CW = 8;
  localparam int NB = DW / SW;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_vld = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_ser_vld;
  logic [SW-1:0] o_ser_data;
  logic          o_ser_sof, o_ser_eof;
  logic          i_ser_rdy = 1'b0;
  logic          o_ovf;
  logic          i_ovf_clr = 1'b0;
  logic [CW-1:0] o_drop_cnt;
  logic [2:0]    o_fifo_level;
  logic          o_busy;

  cordic_out_serializer #(.DATA_WIDTH(DW), .SER_WIDTH(SW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(i_vld), .i_data(i_data),
    .o_ser_vld(o_ser_vld), .o_ser_data(o_ser_data), .o_ser_sof(o_ser_sof),
    .o_ser_eof(o_ser_eof), .i_ser_rdy(i_ser_rdy), .o_ovf(o_ovf),
    .i_ovf_clr(i_ovf_clr), .o_drop_cnt(o_drop_cnt), .o_fifo_level(o_fifo_level),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a queue of accepted words plus the word currently being
  // sent (if any) and how many of its beats have already gone out.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_cur;
  int            m_b;
  bit            m_active;
  bit            m_ovf;
  int            m_cnt;
  int            cyc = 0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mq.delete();
      m_active = 0; m_b = 0; m_cur = '0; m_ovf = 0; m_cnt = 0;
    end else begin
      bit word_done, take, accept, lost;
      cyc++;
      word_done = m_active && i_ser_rdy && (m_b == NB - 1);
      take   = (mq.size() > 0) && (!m_active || word_done);
      accept = i_vld && ((mq.size() < DEPTH) || take);
      lost   = i_vld && !accept;
      if (take) begin
        m_cur = mq.pop_front(); m_b = 0; m_active = 1;
      end else if (word_done) begin
        m_active = 0;
      end else if (m_active && i_ser_rdy) begin
        m_b++;
      end
      if (accept) mq.push_back(i_data);
      if (lost) begin
        m_ovf = 1;
        m_cnt = i_ovf_clr ? 1 : ((m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt);
      end else if (i_ovf_clr) begin
        m_ovf = 0; m_cnt = 0;
      end
    end
  end

  typedef struct { logic [SW-1:0] data; logic sof; logic eof; int c; } beat_t;
  beat_t rx[$];
  int    first_vld_cyc = -1;
  int    lvl_max = 0;

  // Monitor: compares the DUT against the model mid-cycle and logs handshakes.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      logic [DW-1:0] sh;
      chk("ser_vld", o_ser_vld, m_active);
      if (m_active) begin
        sh = m_cur >> (SW * m_b);
        chk("ser_data", o_ser_data, sh[SW-1:0]);
        chk("ser_sof", o_ser_sof, m_b == 0);
        chk("ser_eof", o_ser_eof, m_b == NB - 1);
      end
      chk("fifo_level", o_fifo_level, mq.size());
      chk("busy", o_busy, (mq.size() > 0) || m_active);
      chk("ovf", o_ovf, m_ovf);
      chk("drop_cnt", o_drop_cnt, m_cnt);
      if (o_ser_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (o_ser_vld && i_ser_rdy) rx.push_back('{o_ser_data, o_ser_sof, o_ser_eof, cyc});
      if (int'(o_fifo_level) > lvl_max) lvl_max = int'(o_fifo_level);
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    i_vld = v; i_data = d; i_ser_rdy = r; i_ovf_clr = c;
    @(posedge i_clk); #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_active || mq.size() > 0) && n < budget) begin
      step(0, '0, 1, 0);
      n++;
    end
    if (m_active || mq.size() > 0) chk("drain_timeout", 1, 0);
    step(0, '0, 1, 0);
  endtask

  function automatic logic [SW-1:0] byte_of(logic [DW-1:0] w, int k);
    logic [DW-1:0] t;
    t = w >> (SW * k);
    return t[SW-1:0];
  endfunction

  task automatic check_words(string tag, input logic [DW-1:0] words[$]);
    chk({tag, "_beats"}, rx.size(), words.size() * NB);
    for (int w = 0; w < words.size() && (w * NB + NB - 1) < rx.size(); w++)
      for (int k = 0; k < NB; k++) begin
        chk({tag, "_data"}, rx[w*NB+k].data, byte_of(words[w], k));
        chk({tag, "_sof"}, rx[w*NB+k].sof, k == 0);
        chk({tag, "_eof"}, rx[w*NB+k].eof, k == NB - 1);
      end
  endtask

  initial begin
    logic [DW-1:0] words[$];
    logic [63:0] r64;
    int vc, n;

    // Reset state
    #1;
    chk("rst_ser_vld", o_ser_vld, 0);
    chk("rst_ser_data", o_ser_data, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_cnt", o_drop_cnt, 0);
    chk("rst_level", o_fifo_level, 0);
    chk("rst_busy", o_busy, 0);
    repeat (2) step(0, '0, 0, 0);
    i_rst_n = 1'b1;
    step(0, '0, 1, 0);

    // Single word, rdy held high; first beat two cycles after i_vld
    rx.delete(); first_vld_cyc = -1;
    vc = cyc;
    step(1, 56'h00112233445566, 1, 0);
    drain(50);
    chk("latency", first_vld_cyc - vc, 2);
    words = '{56'h00112233445566};
    check_words("single", words);
    if (rx.size() == NB) begin
      chk("single_b0", rx[0].data, 8'h66);
      chk("single_b6", rx[6].data, 8'h00);
    end

    // Backpressure with rdy pattern 1,0,0
    rx.delete();
    for (int i = 0; i < 40; i++)
      step(i == 0, 56'h00112233445566, (i % 3) == 0, 0);
    drain(50);
    check_words("bp", words);

    // Back-to-back words, no gap between frames
    rx.delete(); lvl_max = 0; words.delete();
    for (int i = 0; i < 3; i++) begin
      r64 = {$urandom(), $urandom()};
      words.push_back(r64[DW-1:0]);
      step(1, r64[DW-1:0], 1, 0);
    end
    drain(60);
    check_words("b2b", words);
    if (rx.size() == 3 * NB) chk("b2b_contig", rx[3*NB-1].c - rx[0].c, 3 * NB - 1);
    chk("b2b_lvl_peak", lvl_max, 2);

    // Overflow: 7 words with rdy low -> 5 kept, 2 dropped
    rx.delete(); words.delete();
    for (int i = 0; i < 7; i++) begin
      r64 = {$urandom(), $urandom()};
      if (i < 5) words.push_back(r64[DW-1:0]);
      step(1, r64[DW-1:0], 0, 0);
    end
    step(0, '0, 0, 0);
    chk("ovf_level", o_fifo_level, 4);
    chk("ovf_flag", o_ovf, 1);
    chk("ovf_cnt", o_drop_cnt, 2);
    drain(100);
    check_words("ovf", words);

    // Clear priority and saturation
    step(0, '0, 0, 1);
    chk("clr_cnt0", o_drop_cnt, 0);
    for (int i = 0; i < 10; i++) step(1, DW'(i), 0, 0);
    chk("pre_clr_cnt", o_drop_cnt, 5);
    step(1, '0, 0, 1);
    chk("clr_drop_ovf", o_ovf, 1);
    chk("clr_drop_cnt", o_drop_cnt, 1);
    step(0, '0, 0, 1);
    chk("clr_only_ovf", o_ovf, 0);
    chk("clr_only_cnt", o_drop_cnt, 0);
    for (int i = 0; i < 300; i++) step(1, DW'(i), 0, 0);
    chk("sat_cnt", o_drop_cnt, 255);
    step(0, '0, 0, 1);
    drain(100);

    // Reset during beat 3 with two words queued
    for (int i = 0; i < 3; i++) step(1, {8'hA0 + 8'(i), 48'h123456789ABC}, 1, 0);
    n = 0;
    while (!(m_active && m_b == 3) && n < 30) begin
      step(0, '0, 1, 0);
      n++;
    end
    chk("rst_mid_reach_beat3", m_active && m_b == 3, 1);
    chk("rst_mid_queued", mq.size(), 2);
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", o_ser_vld, 0);
    chk("rst_mid_data", o_ser_data, 0);
    chk("rst_mid_sof", o_ser_sof, 0);
    chk("rst_mid_eof", o_ser_eof, 0);
    chk("rst_mid_level", o_fifo_level, 0);
    chk("rst_mid_busy", o_busy, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    rx.delete();
    repeat (20) step(0, '0, 1, 0);
    chk("rst_mid_no_stale", rx.size(), 0);
    chk("rst_mid_busy_after", o_busy, 0);

    // Random traffic, checked cycle by cycle by the monitor
    for (int i = 0; i < 3000; i++) begin
      r64 = {$urandom(), $urandom()};
      step(($urandom_range(0, 5) == 0), r64[DW-1:0],
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
    end
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
